mem_access_ctrl: RTL and testbench

Memory-stage access sequencer that produces the data-side inputs of the MEM/WB pipeline latch. It takes the load/store request held in EX/MEM and runs the dREN/dWEN/dhit handshake with the data cache. It registers the load result (dload) and generates the wb_enable/mem_stall pair that advances or freezes the pipeline around the latch. It also terminates the pipeline on halt and keeps a saturating stall-cycle counter for performance debug.

---
 rtl/mem_access_ctrl.sv | 138 +++++++++++++
 tb/tb_mem_access_ctrl.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl
//   Memory-stage access sequencer. It takes the load/store held in EX/MEM and
//   runs the dREN/dWEN/dhit handshake with the data cache. It registers the
//   load result and generates wb_enable/mem_stall for the MEM/WB latch. It
//   parks the pipeline on halt and counts stall cycles with saturation.
//
// Ports
//   CLK, nRST            clock (rising edge), async active-low reset
//   valid_MEM            EX/MEM holds a real instruction
//   memRd_MEM/memWr_MEM  load / store flags
//   halt_MEM             halt instruction
//   addr_MEM, store_MEM  data address and store data
//   mem_flush            squash the instruction in MEM
//   dhit, dload_in       cache completion and read data
//   dREN, dWEN           cache read / write request
//   daddr, dstore        registered request address / store data
//   dload                registered load result
//   wb_enable            MEM/WB capture enable
//   mem_stall            freeze the upstream pipeline registers
//   halt_out             sticky halt indication
//   stall_cnt            saturating count of mem_stall cycles
module mem_access_ctrl #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              valid_MEM,
    input  logic              memRd_MEM,
    input  logic              memWr_MEM,
    input  logic              halt_MEM,
    input  logic [WORD_W-1:0] addr_MEM,
    input  logic [WORD_W-1:0] store_MEM,
    input  logic              mem_flush,
    input  logic              dhit,
    input  logic [WORD_W-1:0] dload_in,
    output logic              dREN,
    output logic              dWEN,
    output logic [WORD_W-1:0] daddr,
    output logic [WORD_W-1:0] dstore,
    output logic [WORD_W-1:0] dload,
    output logic              wb_enable,
    output logic              mem_stall,
    output logic              halt_out,
    output logic [CNT_W-1:0]  stall_cnt
);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE, HALTED} state_t;

    state_t state, state_nxt;
    logic   wr_q;     // request in flight is a store
    logic   drop_q;   // instruction was flushed while its access ran
    logic   start;
    logic   halt_go;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (c == {CNT_W{1'b1}}) ? c : c + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    // A flush always beats a start, so a squashed instruction never issues.
    assign start   = valid_MEM & (memRd_MEM | memWr_MEM) & ~halt_MEM & ~mem_flush;
    assign halt_go = valid_MEM & halt_MEM & ~mem_flush;

    always_comb begin
        state_nxt = state;
        dREN      = 1'b0;
        dWEN      = 1'b0;
        mem_stall = 1'b0;
        wb_enable = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    mem_stall = 1'b1;
                    state_nxt = ACCESS;
                end else if (halt_go) begin
                    // Let the halt itself reach WB before freezing.
                    wb_enable = 1'b1;
                    state_nxt = HALTED;
                end else begin
                    wb_enable = 1'b1;
                end
            end
            ACCESS: begin
                dREN      = ~wr_q;
                dWEN      = wr_q;
                mem_stall = 1'b1;
                if (dhit) state_nxt = DONE;
            end
            DONE: begin
                // Pipeline advances here, so the finished op is not re-detected.
                wb_enable = ~drop_q;
                state_nxt = IDLE;
            end
            HALTED: begin
                mem_stall = 1'b1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state     <= IDLE;
            daddr     <= '0;
            dstore    <= '0;
            dload     <= '0;
            halt_out  <= 1'b0;
            stall_cnt <= '0;
            wr_q      <= 1'b0;
            drop_q    <= 1'b0;
        end else begin
            state <= state_nxt;

            if (state == IDLE && start) begin
                daddr  <= addr_MEM;
                dstore <= store_MEM;
                wr_q   <= memWr_MEM;   // store wins if both flags are set
            end

            // The cache transaction always completes; a flush only
            // suppresses the writeback afterwards.
            if (state == ACCESS && mem_flush)
                drop_q <= 1'b1;
            else if (state == DONE)
                drop_q <= 1'b0;

            if (state == ACCESS && dhit && !wr_q)
                dload <= dload_in;

            if (state == IDLE && halt_go)
                halt_out <= 1'b1;

            if (mem_stall)
                stall_cnt <= sat_inc(stall_cnt);
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
module tb_mem_access_ctrl;

    localparam int WORD_W = 32;
    localparam int CNT_W  = 4;

    logic              CLK = 1'b0;
    logic              nRST = 1'b0;
    logic              valid_MEM = 1'b0, memRd_MEM = 1'b0, memWr_MEM = 1'b0, halt_MEM = 1'b0;
    logic [WORD_W-1:0] addr_MEM = '0, store_MEM = '0, dload_in = '0;
    logic              mem_flush = 1'b0, dhit = 1'b0;
    logic              dREN, dWEN, wb_enable, mem_stall, halt_out;
    logic [WORD_W-1:0] daddr, dstore, dload;
    logic [CNT_W-1:0]  stall_cnt;

    mem_access_ctrl #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .nRST(nRST),
        .valid_MEM(valid_MEM), .memRd_MEM(memRd_MEM), .memWr_MEM(memWr_MEM),
        .halt_MEM(halt_MEM), .addr_MEM(addr_MEM), .store_MEM(store_MEM),
        .mem_flush(mem_flush), .dhit(dhit), .dload_in(dload_in),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload),
        .wb_enable(wb_enable), .mem_stall(mem_stall), .halt_out(halt_out),
        .stall_cnt(stall_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [WORD_W-1:0] dload;
        logic [CNT_W-1:0]  cnt;
        string             tag;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [WORD_W-1:0] d, input logic [CNT_W-1:0] c, input string tag);
        exp_t e;
        e.dload = d;
        e.cnt   = c;
        e.tag   = tag;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Monitor: every writeback of a live, unflushed instruction is scored.
    always @(negedge CLK) begin
        if (nRST && wb_enable && valid_MEM && !mem_flush) begin
            if (q.size() == 0) begin
                chk("unexpected_wb", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk({e.tag, "_dload"}, dload, e.dload);
                chk({e.tag, "_stall_cnt"}, {28'd0, stall_cnt}, {28'd0, e.cnt});
                chk({e.tag, "_stall_vs_wb"}, {31'd0, mem_stall}, 32'd0);
            end
        end
    end

    task automatic alu_op(input string tag);
        valid_MEM = 1'b1; memRd_MEM = 1'b0; memWr_MEM = 1'b0;
        @(negedge CLK);
        chk({tag, "_req"}, {30'd0, dREN, dWEN}, 32'd0);
        step();
        valid_MEM = 1'b0;
    endtask

    // Issue one memory op; dhit arrives in ACCESS cycle lat, optional flush in
    // ACCESS cycle flush_at (0 = none).
    task automatic do_mem(input logic wr, input logic [31:0] addr, input logic [31:0] data,
                          input int lat, input logic [31:0] rdata, input int flush_at,
                          input string tag);
        int rdc = 0, wrc = 0, stc = 0;
        valid_MEM = 1'b1; memRd_MEM = ~wr; memWr_MEM = wr;
        addr_MEM = addr; store_MEM = data;
        @(negedge CLK);
        stc += int'(mem_stall); rdc += int'(dREN); wrc += int'(dWEN);
        step();
        for (int i = 1; i <= lat; i++) begin
            dhit      = (i == lat);
            dload_in  = (i == lat) ? rdata : 32'h0;
            mem_flush = (i == flush_at);
            @(negedge CLK);
            stc += int'(mem_stall); rdc += int'(dREN); wrc += int'(dWEN);
            if (i == lat) begin
                chk({tag, "_daddr"}, daddr, addr);
                if (wr) chk({tag, "_dstore"}, dstore, data);
            end
            step();
        end
        dhit = 1'b0; mem_flush = 1'b0; dload_in = '0;
        @(negedge CLK);
        chk({tag, "_done_req"}, {30'd0, dREN, dWEN}, 32'd0);
        chk({tag, "_done_stall"}, {31'd0, mem_stall}, 32'd0);
        if (flush_at != 0) chk({tag, "_drop_wb"}, {31'd0, wb_enable}, 32'd0);
        step();
        valid_MEM = 1'b0; memRd_MEM = 1'b0; memWr_MEM = 1'b0;
        chk({tag, "_dREN_cycles"}, rdc, wr ? 0 : lat);
        chk({tag, "_dWEN_cycles"}, wrc, wr ? lat : 0);
        chk({tag, "_stall_cycles"}, stc, lat + 1);
    endtask

    initial begin
        int bad_halt, bad_stall, bad_req, bad_wb;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_req", {30'd0, dREN, dWEN}, 32'd0);
        chk("rst_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst_dload", dload, 32'd0);
        chk("rst_halt", {31'd0, halt_out}, 32'd0);
        nRST = 1'b1;
        step();

        push(32'h0, 4'd0, "alu0");
        alu_op("alu0");

        push(32'hDEAD_BEEF, 4'd4, "ld40");
        do_mem(1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF, 0, "ld40");

        push(32'hDEAD_BEEF, 4'd6, "st80");
        do_mem(1'b1, 32'h0000_0080, 32'h1234_5678, 1, 32'h0, 0, "st80");

        // Flushed mid-access: no writeback, but the read still lands in dload.
        do_mem(1'b0, 32'h0000_0050, 32'h0, 3, 32'hCAFE_F00D, 2, "ldfl");
        push(32'hCAFE_F00D, 4'd10, "alu1");
        alu_op("alu1");
        push(32'h0BAD_C0DE, 4'd12, "ld44");
        do_mem(1'b0, 32'h0000_0044, 32'h0, 1, 32'h0BAD_C0DE, 0, "ld44");

        // Flush together with start: nothing is issued.
        valid_MEM = 1'b1; memRd_MEM = 1'b1; mem_flush = 1'b1; addr_MEM = 32'h60;
        @(negedge CLK);
        chk("flst_req0", {31'd0, dREN}, 32'd0);
        chk("flst_stall", {31'd0, mem_stall}, 32'd0);
        step();
        valid_MEM = 1'b0; memRd_MEM = 1'b0; mem_flush = 1'b0;
        @(negedge CLK);
        chk("flst_req1", {31'd0, dREN}, 32'd0);
        chk("flst_cnt", {28'd0, stall_cnt}, 32'd12);
        step();

        // Halt: one writeback, then frozen with dhit and new requests ignored.
        push(32'h0BAD_C0DE, 4'd12, "halt");
        valid_MEM = 1'b1; halt_MEM = 1'b1;
        step();
        halt_MEM = 1'b0; memRd_MEM = 1'b1; dhit = 1'b1;
        bad_halt = 0; bad_stall = 0; bad_req = 0; bad_wb = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge CLK);
            if (halt_out !== 1'b1) bad_halt++;
            if (mem_stall !== 1'b1) bad_stall++;
            if ({dREN, dWEN} !== 2'b00) bad_req++;
            if (wb_enable !== 1'b0) bad_wb++;
            step();
        end
        chk("halt_out_held", bad_halt, 0);
        chk("halt_stall_held", bad_stall, 0);
        chk("halt_no_req", bad_req, 0);
        chk("halt_no_wb", bad_wb, 0);
        chk("halt_cnt_sat", {28'd0, stall_cnt}, 32'h0000_000F);
        valid_MEM = 1'b0; memRd_MEM = 1'b0; dhit = 1'b0;

        nRST = 1'b0;
        #1;
        chk("rst2_halt", {31'd0, halt_out}, 32'd0);
        chk("rst2_cnt", {28'd0, stall_cnt}, 32'd0);
        chk("rst2_dload", dload, 32'd0);
        chk("rst2_daddr", daddr, 32'd0);
        chk("rst2_dstore", dstore, 32'd0);
        chk("rst2_stall", {31'd0, mem_stall}, 32'd0);
        step();
        nRST = 1'b1;
        step();

        // Reset mid-access drops the request immediately.
        valid_MEM = 1'b1; memRd_MEM = 1'b1; addr_MEM = 32'h70;
        step();
        @(negedge CLK);
        chk("racc_dren", {31'd0, dREN}, 32'd1);
        nRST = 1'b0;
        #1;
        chk("racc_drop", {30'd0, dREN, dWEN}, 32'd0);
        valid_MEM = 1'b0; memRd_MEM = 1'b0;
        step();
        nRST = 1'b1;
        step();

        push(32'h0, 4'd0, "alu2");
        alu_op("alu2");
        step();
        chk("sb_empty", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
